pmem_responder: RTL and testbench
=================================

PMEM_RESPONDER -- requirements
Module: pmem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4, meaning cycles from request acceptance to pmem_resp (legal range 1..15).
REQ-002 The block SHALL have parameter LINES, default 32, meaning number of 128-bit lines stored (power of two, 2..256).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 pmem_read  input  1  line read request, level, held by requester until pmem_resp.
REQ-007 pmem_write  input  1  line write request, level, held by requester until pmem_resp.
REQ-008 pmem_address  input  16  byte address (lc3b_word); bits [3:0] ignored.
REQ-009 pmem_wdata  input  128  write line (lc3b_block).
REQ-010 pmem_rdata  output  128  read line; valid only while pmem_resp=1 for a read.
REQ-011 pmem_resp  output  1  one-cycle completion pulse.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 proto_err  output  1  sticky; set when read and write are both sampled high at acceptance.

Function
REQ-014 Storage SHALL be LINES x 128 bits, indexed by pmem_address[4+log2(LINES)-1:4]; higher address bits alias.
REQ-015 FSM states SHALL be IDLE, WAIT, RESP, DONE.
REQ-016 In IDLE with pmem_read|pmem_write=1, the block SHALL accept: latch index, op, and pmem_wdata; load counter with LATENCY-1; go to WAIT.
REQ-017 If both pmem_read and pmem_write are 1 at acceptance, the op SHALL be a write, and proto_err SHALL set to 1 and remain 1 until reset.
REQ-018 In WAIT, the counter SHALL decrement each cycle; on the cycle it reads 0, state SHALL go to RESP.
REQ-019 Total latency SHALL be exactly LATENCY+1 cycles from acceptance edge to the pmem_resp-high cycle (acceptance at edge N, resp high during cycle after edge N+LATENCY).
REQ-020 In RESP, pmem_resp SHALL be 1 for exactly one cycle. For a read, pmem_rdata SHALL equal the stored line at the latched index. For a write, the latched wdata SHALL be written into storage at the RESP->DONE edge.
REQ-021 pmem_rdata SHALL be 0 whenever pmem_resp=0 or the op is a write.
REQ-022 DONE SHALL last exactly one cycle, ignore all requests, and return to IDLE. This prevents re-acceptance of a request still held in the cycle after pmem_resp.
REQ-023 Changes on pmem_address, pmem_wdata, or the request lines after acceptance SHALL NOT affect the in-flight operation.
REQ-024 A read accepted immediately after a write to the same index SHALL return the newly written data.
REQ-025 Back-to-back throughput SHALL be one operation per LATENCY+3 cycles (ACCEPT..DONE) under continuous requests.
REQ-026 No operation SHALL be accepted in WAIT, RESP, or DONE.

Reset
REQ-027 reset_n=0 SHALL immediately force: state IDLE, counter 0, pmem_resp 0, pmem_rdata 0, busy 0, proto_err 0, all storage lines 0.
REQ-028 Reset asserted mid-operation SHALL abort it with no pmem_resp and no storage write. After release, the block SHALL accept on the first rising edge with a request present.

Verification
REQ-029 Reset, then read addr 0x0030 (LATENCY=4) -> pmem_resp high exactly 5 cycles after acceptance, for 1 cycle, with rdata=0; busy high through DONE.
REQ-030 Write 0x0040 data 0x0123...CDEF_ (128-bit pattern), then read 0x0045 -> rdata equals the pattern; read 0x0240 (aliases, LINES=32) -> same pattern.
REQ-031 Requester holds pmem_read one extra cycle after resp -> no second acceptance during DONE. A fresh request in the following cycle -> accepted.
REQ-032 Change address/wdata and deassert the request during WAIT -> response still occurs at the original time with the original operation.
REQ-033 Assert read and write together with wdata=0xAAAA..AA at 0x0010 -> treated as write, proto_err=1 and sticky. A later read of 0x0010 -> 0xAAAA..AA.
REQ-034 Assert reset_n=0 in WAIT of a write to 0x0050 -> no pmem_resp. After release, read 0x0050 -> 0. proto_err=0.

Source files
------------

// File: rtl/pmem_responder.sv
// Line-granular physical memory model with a fixed-latency handshake.
// Each request runs IDLE -> WAIT -> RESP -> DONE; storage updates on RESP exit.
module pmem_responder #(
   parameter int LATENCY = 4,
   parameter int LINES   = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         pmem_read,
   input  logic         pmem_write,
   input  logic [15:0]  pmem_address,
   input  logic [127:0] pmem_wdata,
   output logic [127:0] pmem_rdata,
   output logic         pmem_resp,
   output logic         busy,
   output logic         proto_err
);

   localparam int IDX_W = (LINES > 1) ? $clog2(LINES) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       r_state;
   logic [3:0]       r_cnt;
   logic [IDX_W-1:0] r_idx;
   logic             r_op_wr;
   logic [127:0]     r_wdata;
   logic             r_proto_err;
   logic [127:0]     r_mem [LINES];

   logic             w_accept;
   logic             w_mem_wr;
   logic [127:0]     w_line;
   logic             w_unused_addr;

   assign w_accept      = (r_state == S_IDLE) && (pmem_read || pmem_write);
   assign w_mem_wr      = (r_state == S_RESP) && r_op_wr;
   assign w_line        = r_mem[r_idx];
   assign w_unused_addr = ^{pmem_address[15:4+IDX_W], pmem_address[3:0]};

   // Everything the operation needs is captured at acceptance, so later input changes are harmless.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_idx       <= '0;
         r_op_wr     <= 1'b0;
         r_wdata     <= '0;
         r_proto_err <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state <= S_WAIT;
                  r_cnt   <= 4'(LATENCY - 1);
                  r_idx   <= pmem_address[4+IDX_W-1:4];
                  r_op_wr <= pmem_write;
                  r_wdata <= pmem_wdata;
                  if (pmem_read && pmem_write)
                     r_proto_err <= 1'b1;
               end
            end
            S_WAIT: begin
               if (r_cnt == 4'd0)
                  r_state <= S_RESP;
               else
                  r_cnt <= r_cnt - 4'd1;
            end
            S_RESP:  r_state <= S_DONE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < LINES; gi++) begin : g_line
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
               r_mem[gi] <= '0;
            else if (w_mem_wr && (r_idx == IDX_W'(gi)))
               r_mem[gi] <= r_wdata;
         end
      end
   endgenerate

   assign pmem_resp  = (r_state == S_RESP);
   assign pmem_rdata = (pmem_resp && !r_op_wr) ? w_line : '0;
   assign busy       = (r_state != S_IDLE);
   assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: stimulus pushes expected responses,
// a negedge monitor pops and checks data and response timing.
module tb_pmem_responder;

   localparam int LAT   = 4;
   localparam int LINES = 32;

   localparam logic [127:0] PAT_P = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
   localparam logic [127:0] PAT_Q = 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D;
   localparam logic [127:0] PAT_A = {16{8'hAA}};

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         pmem_read = 1'b0;
   logic         pmem_write = 1'b0;
   logic [15:0]  pmem_address = '0;
   logic [127:0] pmem_wdata = '0;
   logic [127:0] pmem_rdata;
   logic         pmem_resp;
   logic         busy;
   logic         proto_err;

   pmem_responder #(.LATENCY(LAT), .LINES(LINES)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp),
      .busy         (busy),
      .proto_err    (proto_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int acc_cyc = 0;

   typedef struct {
      logic [127:0] rdata;
      int           at;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   logic prev_resp = 1'b0;

   // Response monitor: every resp pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (pmem_resp) begin
         checks++;
         if (prev_resp) begin
            errors++;
            $display("FAIL resp_width cyc=%0d actual=resp_high_2_cycles required=1_cycle", cyc);
         end
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp cyc=%0d actual=resp required=no_resp", cyc);
         end else begin
            mon_e = sb.pop_front();
            checks++;
            if (pmem_rdata !== mon_e.rdata) begin
               errors++;
               $display("FAIL resp_rdata cyc=%0d actual=%h required=%h", cyc, pmem_rdata, mon_e.rdata);
            end
            checks++;
            if (cyc != mon_e.at) begin
               errors++;
               $display("FAIL resp_latency actual_cyc=%0d required_cyc=%0d", cyc, mon_e.at);
            end else
               $display("resp cyc=%0d rdata=%h", cyc, pmem_rdata);
         end
      end else begin
         checks++;
         if (pmem_rdata !== '0) begin
            errors++;
            $display("FAIL rdata_idle_zero cyc=%0d actual=%h required=0", cyc, pmem_rdata);
         end
      end
      prev_resp <= pmem_resp;
   end

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
      end
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   // One transaction: present request, confirm acceptance, wait for resp, walk through DONE.
   task automatic run_op(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [127:0] wd, input logic [127:0] exp_rd,
                         input bit hold_extra, input bit change_mid);
      bit got;
      @(negedge clk);
      chk1("idle_before_req", busy, 1'b0);
      pmem_read    = rd;
      pmem_write   = wr;
      pmem_address = addr;
      pmem_wdata   = wd;
      @(posedge clk);
      #1;
      chk1("accept_busy", busy, 1'b1);
      acc_cyc = cyc;
      sb.push_back('{exp_rd, cyc + LAT});
      $display("op rd=%b wr=%b addr=%h wdata=%h accepted_cyc=%0d", rd, wr, addr, wd, cyc);
      if (change_mid) begin
         @(negedge clk);
         pmem_read    = 1'b0;
         pmem_write   = 1'b0;
         pmem_address = ~addr;
         pmem_wdata   = ~wd;
      end
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (pmem_resp) got = 1'b1;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL resp_timeout addr=%h actual=no_resp required=resp", addr);
      end
      if (hold_extra) begin
         @(negedge clk);
         chk1("done_busy", busy, 1'b1);
         @(negedge clk);
         chk1("no_reaccept_in_done", busy, 1'b0);
         pmem_read  = 1'b0;
         pmem_write = 1'b0;
      end else begin
         pmem_read  = 1'b0;
         pmem_write = 1'b0;
         @(negedge clk);
         chk1("done_busy", busy, 1'b1);
      end
   endtask

   int a0;

   initial begin
      repeat (2) @(negedge clk);
      chk1("reset_resp", pmem_resp, 1'b0);
      chk1("reset_busy", busy, 1'b0);
      chk1("reset_proto_err", proto_err, 1'b0);
      chk("reset_rdata", pmem_rdata, '0);
      reset_n = 1'b1;

      // Read of never-written line returns zero after LAT+1 cycles.
      run_op(1'b1, 1'b0, 16'h0030, '0, '0, 1'b0, 1'b0);

      // Write then reads via ignored offset bits and an aliasing address.
      run_op(1'b0, 1'b1, 16'h0040, PAT_P, '0, 1'b0, 1'b0);
      run_op(1'b1, 1'b0, 16'h0045, '0, PAT_P, 1'b0, 1'b0);
      a0 = acc_cyc;
      run_op(1'b1, 1'b0, 16'h0240, '0, PAT_P, 1'b0, 1'b0);
      chk("throughput_gap", 128'(acc_cyc - a0), 128'(LAT + 3));

      // Request held through DONE must not be re-accepted; next request is.
      run_op(1'b1, 1'b0, 16'h0040, '0, PAT_P, 1'b1, 1'b0);
      run_op(1'b1, 1'b0, 16'h0030, '0, '0, 1'b0, 1'b0);

      // Inputs disturbed during WAIT do not affect the in-flight op.
      run_op(1'b1, 1'b0, 16'h0040, '0, PAT_P, 1'b0, 1'b1);
      run_op(1'b0, 1'b1, 16'h0060, PAT_Q, '0, 1'b0, 1'b1);
      run_op(1'b1, 1'b0, 16'h0060, '0, PAT_Q, 1'b0, 1'b0);
      run_op(1'b1, 1'b0, 16'hFF9F, '0, '0, 1'b0, 1'b0);

      // Simultaneous read+write is a write and flags a sticky error.
      chk1("proto_err_clear", proto_err, 1'b0);
      run_op(1'b1, 1'b1, 16'h0010, PAT_A, '0, 1'b0, 1'b0);
      chk1("proto_err_set", proto_err, 1'b1);
      run_op(1'b1, 1'b0, 16'h0010, '0, PAT_A, 1'b0, 1'b0);
      chk1("proto_err_sticky", proto_err, 1'b1);

      // Reset during WAIT of a write aborts it and clears storage and flags.
      @(negedge clk);
      pmem_write   = 1'b1;
      pmem_address = 16'h0050;
      pmem_wdata   = PAT_Q;
      @(posedge clk);
      #1;
      chk1("abort_accept_busy", busy, 1'b1);
      $display("op wr addr=0050 accepted_cyc=%0d then reset", cyc);
      @(negedge clk);
      pmem_write = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk1("async_reset_busy", busy, 1'b0);
      chk1("async_reset_resp", pmem_resp, 1'b0);
      chk1("async_reset_proto_err", proto_err, 1'b0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (8) @(negedge clk);
      run_op(1'b1, 1'b0, 16'h0050, '0, '0, 1'b0, 1'b0);
      run_op(1'b1, 1'b0, 16'h0040, '0, '0, 1'b0, 1'b0);
      chk1("proto_err_after_reset", proto_err, 1'b0);

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 128'(sb.size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
